// File: rtl/rtc_bus_reader_if.sv
// rtl/rtc_bus_reader_if.sv - multiplexed 8-bit RTC address/data bus
interface rtc_bus_reader_if;
  logic [7:0] AD_IN;
  logic [7:0] AD_OUT;
  logic       AD_OE;
  logic       CS_N;
  logic       RD_N;
  logic       WR_N;
  logic       AD_N;

  modport master (
    input  AD_IN,
    output AD_OUT, AD_OE, CS_N, RD_N, WR_N, AD_N
  );

  modport slave (
    output AD_IN,
    input  AD_OUT, AD_OE, CS_N, RD_N, WR_N, AD_N
  );
endinterface

// File: rtl/rtc_bus_reader.sv
// rtl/rtc_bus_reader.sv - periodic RTC scanner latching BCD date/time/timer for display
module rtc_bus_reader #(
  parameter int T_PULSE        = 8,
  parameter int T_GAP          = 4,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCAN_EN,
  input  logic                  TIMER_EN,
  input  logic                  ALARM_ACK,
  rtc_bus_reader_if.master      bus,
  output logic [7:0]            ANO,
  output logic [7:0]            MES,
  output logic [7:0]            DIA,
  output logic [7:0]            HORA,
  output logic [7:0]            MIN,
  output logic [7:0]            SEG,
  output logic [7:0]            HORAT,
  output logic [7:0]            MINT,
  output logic [7:0]            SEGT,
  output logic                  ALARMA,
  output logic                  BUSY,
  output logic                  SCAN_DONE
);

  localparam int T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int PW    = $clog2(T_MAX + 1);
  localparam int RW    = $clog2(REFRESH_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(T_PULSE - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(T_GAP - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD,
    DATA_SETUP, DATA_STROBE, DATA_HOLD, GAP, COMMIT
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] tcnt, tcnt_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [RW-1:0] ref_cnt;
  logic          wrap_q;
  logic          sample;
  logic          addr_phase, data_phase, commit, timer_zero;
  logic [7:0]    shadow [1:9];

  // Access 0 is the clock-to-buffer command; 1..9 are the register reads.
  function automatic logic [7:0] access_addr(input logic [3:0] i);
    case (i)
      4'd0:    access_addr = 8'hF0;
      4'd1:    access_addr = 8'h21;
      4'd2:    access_addr = 8'h22;
      4'd3:    access_addr = 8'h23;
      4'd4:    access_addr = 8'h24;
      4'd5:    access_addr = 8'h25;
      4'd6:    access_addr = 8'h26;
      4'd7:    access_addr = 8'h41;
      4'd8:    access_addr = 8'h42;
      4'd9:    access_addr = 8'h43;
      default: access_addr = 8'h00;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ref_cnt <= '0;
      wrap_q  <= 1'b0;
    end else begin
      ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
      wrap_q  <= (ref_cnt == REF_LAST);
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = '0;
    idx_nxt   = idx;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (wrap_q && SCAN_EN) begin
          state_nxt = ADDR_SETUP;
          idx_nxt   = 4'd0;
        end
      end
      ADDR_SETUP: state_nxt = ADDR_STROBE;
      ADDR_STROBE: begin
        if (tcnt == PULSE_LAST) state_nxt = ADDR_HOLD;
        else                    tcnt_nxt  = tcnt + 1'b1;
      end
      ADDR_HOLD:  state_nxt = (idx == 4'd0) ? GAP : DATA_SETUP;
      DATA_SETUP: state_nxt = DATA_STROBE;
      DATA_STROBE: begin
        if (tcnt == PULSE_LAST) begin
          state_nxt = DATA_HOLD;
          sample    = 1'b1;
        end else begin
          tcnt_nxt  = tcnt + 1'b1;
        end
      end
      DATA_HOLD: state_nxt = GAP;
      GAP: begin
        if (tcnt != GAP_LAST) begin
          tcnt_nxt = tcnt + 1'b1;
        end else if (idx < 4'd9) begin
          idx_nxt   = idx + 4'd1;
          state_nxt = ADDR_SETUP;
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    addr_phase = (state_nxt == ADDR_SETUP) || (state_nxt == ADDR_STROBE) || (state_nxt == ADDR_HOLD);
    data_phase = (state_nxt == DATA_SETUP) || (state_nxt == DATA_STROBE) || (state_nxt == DATA_HOLD);
    commit     = (state_nxt == COMMIT);
    timer_zero = (shadow[7] == 8'h00) && (shadow[8] == 8'h00) && (shadow[9] == 8'h00);
  end

  // Pins are registered from the next state so they change cleanly on the clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      tcnt       <= '0;
      idx        <= 4'd0;
      bus.CS_N   <= 1'b1;
      bus.RD_N   <= 1'b1;
      bus.WR_N   <= 1'b1;
      bus.AD_N   <= 1'b1;
      bus.AD_OE  <= 1'b0;
      bus.AD_OUT <= 8'h00;
      BUSY       <= 1'b0;
      SCAN_DONE  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      idx        <= idx_nxt;
      bus.CS_N   <= !(addr_phase || data_phase);
      bus.RD_N   <= (state_nxt != DATA_STROBE);
      bus.WR_N   <= (state_nxt != ADDR_STROBE);
      bus.AD_N   <= !addr_phase;
      bus.AD_OE  <= addr_phase;
      bus.AD_OUT <= addr_phase ? access_addr(idx_nxt) : 8'h00;
      BUSY       <= (state_nxt != IDLE);
      SCAN_DONE  <= commit;
    end
  end

  // Reads land in shadow slots; the visible registers only move together at commit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 1; i <= 9; i++) shadow[i] <= 8'h00;
      SEG    <= 8'h00;
      MIN    <= 8'h00;
      HORA   <= 8'h00;
      DIA    <= 8'h00;
      MES    <= 8'h00;
      ANO    <= 8'h00;
      SEGT   <= 8'h00;
      MINT   <= 8'h00;
      HORAT  <= 8'h00;
      ALARMA <= 1'b0;
    end else begin
      if (sample) shadow[idx] <= bus.AD_IN;
      if (commit) begin
        SEG   <= shadow[1];
        MIN   <= shadow[2];
        HORA  <= shadow[3];
        DIA   <= shadow[4];
        MES   <= shadow[5];
        ANO   <= shadow[6];
        SEGT  <= shadow[7];
        MINT  <= shadow[8];
        HORAT <= shadow[9];
      end
      if (commit && TIMER_EN && timer_zero) ALARMA <= 1'b1;
      else if (ALARM_ACK || !TIMER_EN)      ALARMA <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// tb/tb_rtc_bus_reader.sv - scoreboard bench for rtc_bus_reader with an RTC bus model
module tb_rtc_bus_reader;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SCAN_EN = 1'b0;
  logic       TIMER_EN = 1'b0;
  logic       ALARM_ACK = 1'b0;
  logic [7:0] ANO, MES, DIA, HORA, MIN, SEG, HORAT, MINT, SEGT;
  logic       ALARMA, BUSY, SCAN_DONE;

  rtc_bus_reader_if bus();

  rtc_bus_reader #(.T_PULSE(4), .T_GAP(2), .REFRESH_CYCLES(200)) dut (
    .CLK(CLK), .RST(RST), .SCAN_EN(SCAN_EN), .TIMER_EN(TIMER_EN), .ALARM_ACK(ALARM_ACK),
    .bus(bus),
    .ANO(ANO), .MES(MES), .DIA(DIA), .HORA(HORA), .MIN(MIN), .SEG(SEG),
    .HORAT(HORAT), .MINT(MINT), .SEGT(SEGT),
    .ALARMA(ALARMA), .BUSY(BUSY), .SCAN_DONE(SCAN_DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int viol = 0;
  int cyc = 0;
  int rel = 0;

  logic [7:0]  rtc_mem [256];
  logic [7:0]  bus_addr = 8'h00;
  logic [72:0] exp_q [$];
  logic [7:0]  obs_addr [$];
  logic [71:0] bcd_now;

  assign bus.AD_IN = rtc_mem[bus_addr];
  assign bcd_now = {ANO, MES, DIA, HORA, MIN, SEG, HORAT, MINT, SEGT};

  task automatic chk_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mk_exp(input logic alarm);
    return {rtc_mem[8'h26], rtc_mem[8'h25], rtc_mem[8'h24], rtc_mem[8'h23], rtc_mem[8'h22],
            rtc_mem[8'h21], rtc_mem[8'h43], rtc_mem[8'h42], rtc_mem[8'h41], alarm};
  endfunction

  function automatic logic [7:0] exp_addr(input int i);
    case (i)
      0: return 8'hF0;  1: return 8'h21;  2: return 8'h22;  3: return 8'h23;  4: return 8'h24;
      5: return 8'h25;  6: return 8'h26;  7: return 8'h41;  8: return 8'h42;  default: return 8'h43;
    endcase
  endfunction

  task automatic mem_default();
    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'(i + 16);
  endtask

  initial forever @(posedge CLK) cyc++;

  // RTC side: latch the address driven during the address phase.
  initial forever @(negedge CLK)
    if (!bus.CS_N && !bus.AD_N && bus.AD_OE) bus_addr = bus.AD_OUT;

  // Protocol monitor.
  initial begin
    int wr_run = 0;
    int rd_run = 0;
    logic [71:0] prev_bcd = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        obs_addr.delete();
        wr_run = 0;
        rd_run = 0;
      end else begin
        if (!bus.RD_N && !bus.WR_N) viol++;
        if ((!bus.RD_N || !bus.WR_N) && bus.CS_N) viol++;
        if (bus.AD_OE && bus.AD_N) viol++;
        if (!SCAN_DONE && bcd_now !== prev_bcd) viol++;
        if (!bus.WR_N) begin
          if (wr_run == 0) obs_addr.push_back(bus.AD_OUT);
          wr_run++;
        end else begin
          if (wr_run != 0 && wr_run != 4) viol++;
          wr_run = 0;
        end
        if (!bus.RD_N) rd_run++;
        else begin
          if (rd_run != 0 && rd_run != 4) viol++;
          rd_run = 0;
        end
      end
      prev_bcd = bcd_now;
    end
  end

  // Scoreboard: each committed scan is compared against the oldest expected record.
  initial forever begin
    @(negedge CLK);
    if (RST && SCAN_DONE) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_unexpected_commit", 1, 0);
      end else begin
        logic [72:0] e;
        e = exp_q.pop_front();
        chk_eq("sb_bcd", bcd_now, e[72:1]);
        chk_eq("sb_alarma", ALARMA, e[0]);
      end
      chk_eq("addr_count", obs_addr.size(), 10);
      for (int i = 0; i < 10 && i < obs_addr.size(); i++) chk_eq("addr_order", obs_addr[i], exp_addr(i));
      obs_addr.delete();
    end
  end

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (BUSY !== lvl && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk_eq(tag, BUSY, lvl);
  endtask

  task automatic release_and_time(output int n);
    @(negedge CLK);
    RST = 1'b1;
    rel = cyc;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.CS_N !== 1'b0 && n < 2000);
  endtask

  initial begin
    int n;
    mem_default();
    SCAN_EN = 1'b1;
    repeat (3) @(negedge CLK);
    chk_eq("rst_pins", {bus.CS_N, bus.RD_N, bus.WR_N, bus.AD_N, bus.AD_OE}, 5'b11110);
    chk_eq("rst_ad_out", bus.AD_OUT, 8'h00);
    chk_eq("rst_bcd", bcd_now, 72'h0);
    chk_eq("rst_flags", {ALARMA, BUSY, SCAN_DONE}, 3'b000);

    // Scan 1: first access timing and BUSY length.
    exp_q.push_back(mk_exp(1'b0));
    release_and_time(n);
    chk_eq("first_cs_fall", n, 201);
    chk_eq("first_addr", bus.AD_OUT, 8'hF0);
    n = 1;
    while (BUSY === 1'b1 && n < 1000) begin
      @(negedge CLK);
      if (BUSY === 1'b1) n++;
    end
    chk_eq("busy_len", n, 135);
    chk_eq("scan1_seg", SEG, 8'h31);

    // Scan 2: RTC changes SEG after it was read; the old value must commit atomically.
    rtc_mem[8'h21] = 8'h59;
    exp_q.push_back(mk_exp(1'b0));
    wait_busy(1'b1, "scan2_start");
    n = 0;
    while (!(bus.RD_N === 1'b0 && bus_addr == 8'h21) && n < 2000) begin @(negedge CLK); n++; end
    while (bus.RD_N !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    chk_eq("seg_read_seen", n < 2000, 1'b1);
    rtc_mem[8'h21] = 8'h00;
    chk_eq("seg_midscan_hold", SEG, 8'h31);
    wait_busy(1'b0, "scan2_end");
    chk_eq("seg_after_commit", SEG, 8'h59);

    // Scan 3: timer reads zero with TIMER_EN -> alarm.
    rtc_mem[8'h41] = 8'h00;
    rtc_mem[8'h42] = 8'h00;
    rtc_mem[8'h43] = 8'h00;
    TIMER_EN = 1'b1;
    exp_q.push_back(mk_exp(1'b1));
    wait_busy(1'b1, "scan3_start");
    wait_busy(1'b0, "scan3_end");
    chk_eq("alarm_set", ALARMA, 1'b1);

    // Scan 4: ack coincides with the commit that sets the alarm again -> set wins.
    exp_q.push_back(mk_exp(1'b1));
    wait_busy(1'b1, "scan4_start");
    repeat (133) @(posedge CLK);
    @(negedge CLK);
    ALARM_ACK = 1'b1;
    @(negedge CLK);
    ALARM_ACK = 1'b0;
    chk_eq("ack_commit_align", SCAN_DONE, 1'b1);
    chk_eq("alarm_set_wins", ALARMA, 1'b1);
    @(negedge CLK);
    ALARM_ACK = 1'b1;
    @(negedge CLK);
    ALARM_ACK = 1'b0;
    chk_eq("alarm_ack_clear", ALARMA, 1'b0);

    // Scan 5: async reset during the 0x23 read strobe.
    mem_default();
    TIMER_EN = 1'b0;
    wait_busy(1'b1, "scan5_start");
    n = 0;
    while (!(bus.RD_N === 1'b0 && bus_addr == 8'h23) && n < 2000) begin @(negedge CLK); n++; end
    chk_eq("strobe_23_seen", n < 2000, 1'b1);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk_eq("async_rst_pins", {bus.CS_N, bus.RD_N, bus.WR_N}, 3'b111);
    chk_eq("async_rst_bcd", bcd_now, 72'h0);
    chk_eq("async_rst_busy", BUSY, 1'b0);
    exp_q.push_back(mk_exp(1'b0));
    release_and_time(n);
    chk_eq("post_rst_cs_fall", n, 201);
    wait_busy(1'b0, "scan5_end");

    // Scan 6: disabled across wraps at +400 and +600, enabled before +800.
    SCAN_EN = 1'b0;
    n = 0;
    while (cyc - rel < 650) begin
      @(negedge CLK);
      if (bus.CS_N !== 1'b1) n++;
    end
    chk_eq("disabled_no_cs", n, 0);
    SCAN_EN = 1'b1;
    exp_q.push_back(mk_exp(1'b0));
    n = 0;
    while (bus.CS_N !== 1'b0 && n < 1000) begin @(negedge CLK); n++; end
    chk_eq("reenable_start", cyc - rel, 801);
    wait_busy(1'b0, "scan6_end");
    @(negedge CLK);

    chk_eq("protocol_viol", viol, 0);
    chk_eq("sb_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
